// File: rtl/fetch_ctrl_pkg.sv
// Shared types and constants for the instruction fetch controller.
package fetch_ctrl_pkg;

   localparam int unsigned XLEN   = 16;
   localparam int unsigned WDOG_W = 8;

   typedef enum logic [2:0] {
      RSTV  = 3'd0,
      FETCH = 3'd1,
      ISSUE = 3'd2,
      HALT  = 3'd3,
      FAULT = 3'd4
   } state_t;

endpackage

// File: rtl/fetch_wdog.sv
// Fetch timeout watchdog: counts cycles spent waiting for a memory response.
module fetch_wdog
   import fetch_ctrl_pkg::*;
#(
   parameter int unsigned MAX_WAIT = 16
) (
   input  logic clk,
   input  logic reset,
   input  logic clr,
   input  logic en,
   output logic expired
);

   logic [WDOG_W-1:0] cnt;

   // Wait counter: cleared outside a pending fetch, advances while waiting.
   always_ff @(posedge clk) begin
      if (!reset) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= cnt + WDOG_W'(1);
      end
   end

   // Last allowed waiting cycle without a response.
   assign expired = en && (cnt == WDOG_W'(MAX_WAIT - 1));

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: drives the PC, issues reads, holds the IR.
module fetch_ctrl
   import fetch_ctrl_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_VEC = 16'h0000,
   parameter int unsigned     MAX_WAIT  = 16
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [XLEN-1:0] pc_out,
   output logic [XLEN-1:0] pc_in,
   output logic            pc_ld,
   output logic            pc_inc,
   output logic            mem_req,
   output logic [XLEN-1:0] mem_addr,
   input  logic            mem_ack,
   input  logic [XLEN-1:0] mem_rdata,
   output logic [XLEN-1:0] ir,
   output logic            ir_valid,
   input  logic            ir_ready,
   input  logic            br_valid,
   input  logic [XLEN-1:0] br_target,
   input  logic            halt,
   output logic            fault
);

   state_t          state;
   state_t          state_nxt;
   logic            br_pend;
   logic [XLEN-1:0] br_tgt;
   logic            in_fetch;
   logic            redirect;
   logic            wd_clr;
   logic            wd_en;
   logic            wd_expired;

   assign in_fetch = (state == FETCH);
   assign redirect = br_pend || br_valid;
   assign wd_en    = in_fetch && !mem_ack;
   assign wd_clr   = !in_fetch || mem_ack;
   assign mem_addr = pc_out;

   fetch_wdog #(
      .MAX_WAIT (MAX_WAIT)
   ) u_wdog (
      .clk     (clk),
      .reset   (reset),
      .clr     (wd_clr),
      .en      (wd_en),
      .expired (wd_expired)
   );

   // Next-state and PC control; branch redirects win over acceptance.
   always_comb begin
      state_nxt = state;
      pc_ld     = 1'b0;
      pc_inc    = 1'b0;
      pc_in     = '0;
      case (state)
         RSTV: begin
            pc_ld     = 1'b1;
            pc_in     = RESET_VEC;
            state_nxt = FETCH;
         end
         FETCH: begin
            if (mem_ack) begin
               if (redirect) begin
                  pc_ld = 1'b1;
                  pc_in = br_valid ? br_target : br_tgt;
               end else begin
                  state_nxt = ISSUE;
               end
            end else if (wd_expired) begin
               state_nxt = FAULT;
            end
         end
         ISSUE: begin
            if (br_valid) begin
               pc_ld     = 1'b1;
               pc_in     = br_target;
               state_nxt = FETCH;
            end else if (ir_ready) begin
               pc_inc    = 1'b1;
               state_nxt = halt ? HALT : FETCH;
            end
         end
         HALT: begin
            if (!halt) begin
               state_nxt = FETCH;
            end
         end
         FAULT: begin
            state_nxt = FAULT;
         end
         default: begin
            state_nxt = RSTV;
         end
      endcase
   end

   // State, registered status outputs, IR capture and pending-branch tracking.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state    <= RSTV;
         mem_req  <= 1'b0;
         ir_valid <= 1'b0;
         fault    <= 1'b0;
         ir       <= '0;
         br_pend  <= 1'b0;
         br_tgt   <= '0;
      end else begin
         state    <= state_nxt;
         mem_req  <= (state_nxt == FETCH);
         ir_valid <= (state_nxt == ISSUE);
         fault    <= (state_nxt == FAULT);
         if (in_fetch) begin
            if (mem_ack) begin
               br_pend <= 1'b0;
               if (!redirect) begin
                  ir <= mem_rdata;
               end
            end else if (br_valid) begin
               br_pend <= 1'b1;
               br_tgt  <= br_target;
            end
         end
      end
   end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed vector bench for fetch_ctrl with a behavioural program counter.
module tb_fetch_ctrl;

   logic        clk;
   logic        reset;
   logic [15:0] pc_out;
   logic [15:0] pc_in;
   logic        pc_ld;
   logic        pc_inc;
   logic        mem_req;
   logic [15:0] mem_addr;
   logic        mem_ack;
   logic [15:0] mem_rdata;
   logic [15:0] ir;
   logic        ir_valid;
   logic        ir_ready;
   logic        br_valid;
   logic [15:0] br_target;
   logic        halt;
   logic        fault;

   int n_vec;
   int n_err;

   typedef struct {
      logic        ack;
      logic [15:0] rdata;
      logic        rdy;
      logic        brv;
      logic [15:0] brt;
      logic        hlt;
      logic        e_ld;
      logic        e_inc;
      logic [15:0] e_pcin;
      logic        e_req;
      logic [15:0] e_addr;
      logic        e_irv;
      logic [15:0] e_ir;
      logic        e_flt;
   } vec_t;

   localparam int NVEC = 30;
   vec_t tbl [NVEC];

   fetch_ctrl #(
      .RESET_VEC (16'h0100),
      .MAX_WAIT  (16)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .pc_out    (pc_out),
      .pc_in     (pc_in),
      .pc_ld     (pc_ld),
      .pc_inc    (pc_inc),
      .mem_req   (mem_req),
      .mem_addr  (mem_addr),
      .mem_ack   (mem_ack),
      .mem_rdata (mem_rdata),
      .ir        (ir),
      .ir_valid  (ir_valid),
      .ir_ready  (ir_ready),
      .br_valid  (br_valid),
      .br_target (br_target),
      .halt      (halt),
      .fault     (fault)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Program counter model: load has priority over increment.
   initial pc_out = 16'h0000;
   always @(posedge clk) begin
      if (pc_ld) pc_out <= pc_in;
      else if (pc_inc) pc_out <= pc_out + 16'd1;
   end

   function automatic vec_t mk(logic ack, logic [15:0] rd, logic rdy, logic brv,
                               logic [15:0] brt, logic hlt, logic eld, logic einc,
                               logic [15:0] epc, logic ereq, logic [15:0] eaddr,
                               logic eirv, logic [15:0] eir, logic eflt);
      vec_t v;
      v.ack = ack;  v.rdata = rd;  v.rdy = rdy;  v.brv = brv;  v.brt = brt;  v.hlt = hlt;
      v.e_ld = eld; v.e_inc = einc; v.e_pcin = epc; v.e_req = ereq; v.e_addr = eaddr;
      v.e_irv = eirv; v.e_ir = eir; v.e_flt = eflt;
      return v;
   endfunction

   task automatic chk(input string name, input int row, input logic [15:0] act,
                      input logic [15:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s (row %0d): got %h, expected %h", name, row, act, exp);
      end
   endtask

   task automatic drive(input logic ack, input logic [15:0] rd, input logic rdy,
                        input logic brv, input logic [15:0] brt, input logic hlt);
      mem_ack   = ack;
      mem_rdata = rd;
      ir_ready  = rdy;
      br_valid  = brv;
      br_target = brt;
      halt      = hlt;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;

      // Reset behaviour and the normal fetch/issue flow, one row per cycle.
      tbl[0]  = mk(0, 16'h0000, 0, 0, 16'h0000, 0,  1, 0, 16'h0100, 0, 16'h0000, 0, 16'h0000, 0);
      tbl[1]  = mk(0, 16'h0000, 0, 0, 16'h0000, 0,  0, 0, 16'h0000, 1, 16'h0100, 0, 16'h0000, 0);
      tbl[2]  = mk(1, 16'hA001, 0, 0, 16'h0000, 0,  0, 0, 16'h0000, 1, 16'h0100, 0, 16'h0000, 0);
      tbl[3]  = mk(0, 16'h0000, 1, 0, 16'h0000, 0,  0, 1, 16'h0000, 0, 16'h0000, 1, 16'hA001, 0);
      tbl[4]  = mk(1, 16'hA002, 0, 0, 16'h0000, 0,  0, 0, 16'h0000, 1, 16'h0101, 0, 16'hA001, 0);
      for (int i = 5; i < 10; i++)
         tbl[i] = mk(0, 16'h0000, 0, 0, 16'h0000, 0,  0, 0, 16'h0000, 0, 16'h0000, 1, 16'hA002, 0);
      tbl[10] = mk(0, 16'h0000, 1, 0, 16'h0000, 0,  0, 1, 16'h0000, 0, 16'h0000, 1, 16'hA002, 0);
      // Branch while waiting, response three cycles later is dropped.
      tbl[11] = mk(0, 16'h0000, 0, 1, 16'h0040, 0,  0, 0, 16'h0000, 1, 16'h0102, 0, 16'hA002, 0);
      tbl[12] = mk(0, 16'h0000, 0, 0, 16'h0000, 0,  0, 0, 16'h0000, 1, 16'h0102, 0, 16'hA002, 0);
      tbl[13] = mk(0, 16'h0000, 0, 0, 16'h0000, 0,  0, 0, 16'h0000, 1, 16'h0102, 0, 16'hA002, 0);
      tbl[14] = mk(1, 16'hDEAD, 0, 0, 16'h0000, 0,  1, 0, 16'h0040, 1, 16'h0102, 0, 16'hA002, 0);
      tbl[15] = mk(1, 16'hB001, 0, 0, 16'h0000, 0,  0, 0, 16'h0000, 1, 16'h0040, 0, 16'hA002, 0);
      // Branch and accept together: branch wins.
      tbl[16] = mk(0, 16'h0000, 1, 1, 16'h0200, 0,  1, 0, 16'h0200, 0, 16'h0000, 1, 16'hB001, 0);
      tbl[17] = mk(1, 16'hB002, 0, 0, 16'h0000, 0,  0, 0, 16'h0000, 1, 16'h0200, 0, 16'hB001, 0);
      // Halt at accept, branch ignored in HALT, resume at incremented PC.
      tbl[18] = mk(0, 16'h0000, 1, 0, 16'h0000, 1,  0, 1, 16'h0000, 0, 16'h0000, 1, 16'hB002, 0);
      tbl[19] = mk(0, 16'h0000, 0, 1, 16'h0300, 1,  0, 0, 16'h0000, 0, 16'h0000, 0, 16'hB002, 0);
      tbl[20] = mk(0, 16'h0000, 0, 0, 16'h0000, 1,  0, 0, 16'h0000, 0, 16'h0000, 0, 16'hB002, 0);
      tbl[21] = mk(0, 16'h0000, 0, 0, 16'h0000, 0,  0, 0, 16'h0000, 0, 16'h0000, 0, 16'hB002, 0);
      // Branch in the same cycle as the response.
      tbl[22] = mk(1, 16'hC001, 0, 1, 16'h0050, 0,  1, 0, 16'h0050, 1, 16'h0201, 0, 16'hB002, 0);
      tbl[23] = mk(0, 16'h0000, 0, 0, 16'h0000, 0,  0, 0, 16'h0000, 1, 16'h0050, 0, 16'hB002, 0);
      tbl[24] = mk(1, 16'hC002, 0, 0, 16'h0000, 0,  0, 0, 16'h0000, 1, 16'h0050, 0, 16'hB002, 0);
      tbl[25] = mk(0, 16'h0000, 1, 0, 16'h0000, 0,  0, 1, 16'h0000, 0, 16'h0000, 1, 16'hC002, 0);
      // Second branch while waiting overwrites the first target.
      tbl[26] = mk(0, 16'h0000, 0, 1, 16'h0060, 0,  0, 0, 16'h0000, 1, 16'h0051, 0, 16'hC002, 0);
      tbl[27] = mk(0, 16'h0000, 0, 1, 16'h0070, 0,  0, 0, 16'h0000, 1, 16'h0051, 0, 16'hC002, 0);
      tbl[28] = mk(1, 16'hEEEE, 0, 0, 16'h0000, 0,  1, 0, 16'h0070, 1, 16'h0051, 0, 16'hC002, 0);
      tbl[29] = mk(0, 16'h0000, 0, 0, 16'h0000, 0,  0, 0, 16'h0000, 1, 16'h0070, 0, 16'hC002, 0);

      // Hold reset for two edges, then check the RSTV outputs.
      reset = 1'b0;
      drive(0, 16'h0000, 0, 0, 16'h0000, 0);
      next_cycle();
      next_cycle();
      @(negedge clk);
      chk("rst pc_ld",    -1, 16'(pc_ld),    16'h0001);
      chk("rst pc_in",    -1, pc_in,         16'h0100);
      chk("rst pc_inc",   -1, 16'(pc_inc),   16'h0000);
      chk("rst mem_req",  -1, 16'(mem_req),  16'h0000);
      chk("rst ir_valid", -1, 16'(ir_valid), 16'h0000);
      chk("rst fault",    -1, 16'(fault),    16'h0000);
      chk("rst ir",       -1, ir,            16'h0000);
      next_cycle();
      reset = 1'b1;

      // Table: inputs applied for one cycle, outputs checked mid-cycle.
      for (int r = 0; r < NVEC; r++) begin
         drive(tbl[r].ack, tbl[r].rdata, tbl[r].rdy, tbl[r].brv, tbl[r].brt, tbl[r].hlt);
         @(negedge clk);
         chk("pc_ld",    r, 16'(pc_ld),    16'(tbl[r].e_ld));
         chk("pc_inc",   r, 16'(pc_inc),   16'(tbl[r].e_inc));
         if (tbl[r].e_ld) chk("pc_in", r, pc_in, tbl[r].e_pcin);
         chk("mem_req",  r, 16'(mem_req),  16'(tbl[r].e_req));
         if (tbl[r].e_req) chk("mem_addr", r, mem_addr, tbl[r].e_addr);
         chk("ir_valid", r, 16'(ir_valid), 16'(tbl[r].e_irv));
         chk("ir",       r, ir,            tbl[r].e_ir);
         chk("fault",    r, 16'(fault),    16'(tbl[r].e_flt));
         next_cycle();
      end

      // Timeout: restart from reset, never acknowledge.
      reset = 1'b0;
      drive(0, 16'h0000, 0, 0, 16'h0000, 0);
      next_cycle();
      reset = 1'b1;
      @(negedge clk);
      chk("to rstv pc_ld", -1, 16'(pc_ld), 16'h0001);
      next_cycle();
      for (int k = 1; k <= 16; k++) begin
         @(negedge clk);
         chk("to wait mem_req", k, 16'(mem_req), 16'h0001);
         chk("to wait addr",    k, mem_addr,     16'h0100);
         chk("to wait fault",   k, 16'(fault),   16'h0000);
         next_cycle();
      end
      // Fault is sticky and blocks everything, even with traffic on the inputs.
      drive(1, 16'h1234, 1, 1, 16'h0040, 0);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("fault set",     k, 16'(fault),    16'h0001);
         chk("fault mem_req", k, 16'(mem_req),  16'h0000);
         chk("fault pc_ld",   k, 16'(pc_ld),    16'h0000);
         chk("fault pc_inc",  k, 16'(pc_inc),   16'h0000);
         chk("fault ir_valid",k, 16'(ir_valid), 16'h0000);
         next_cycle();
      end

      // Reset clears the fault; a late response during RSTV is ignored.
      reset = 1'b0;
      drive(1, 16'hFFFF, 0, 0, 16'h0000, 0);
      next_cycle();
      reset = 1'b1;
      @(negedge clk);
      chk("clr fault",   -1, 16'(fault),   16'h0000);
      chk("clr mem_req", -1, 16'(mem_req), 16'h0000);
      chk("clr pc_ld",   -1, 16'(pc_ld),   16'h0001);
      chk("clr pc_in",   -1, pc_in,        16'h0100);
      next_cycle();
      drive(0, 16'h0000, 0, 0, 16'h0000, 0);
      @(negedge clk);
      chk("late ack mem_req",  -1, 16'(mem_req),  16'h0001);
      chk("late ack addr",     -1, mem_addr,      16'h0100);
      chk("late ack ir_valid", -1, 16'(ir_valid), 16'h0000);
      chk("late ack ir",       -1, ir,            16'h0000);

      // Reset in the middle of a fetch drops the request next cycle.
      reset = 1'b0;
      next_cycle();
      @(negedge clk);
      chk("midrst mem_req", -1, 16'(mem_req), 16'h0000);
      reset = 1'b1;
      next_cycle();
      drive(1, 16'h5A5A, 0, 0, 16'h0000, 0);
      next_cycle();
      drive(0, 16'h0000, 0, 0, 16'h0000, 0);
      @(negedge clk);
      chk("refetch ir_valid", -1, 16'(ir_valid), 16'h0001);
      chk("refetch ir",       -1, ir,            16'h5A5A);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter: RESET_VEC, 16'h0000, address loaded into the PC after reset.
REQ-002 Parameter: MAX_WAIT, 16, maximum cycles FETCH waits for mem_ack before faulting (range 2..255).
REQ-003 Port: clk  in  1  single clock; all state updates on the rising edge.
REQ-004 Port: reset  in  1  synchronous, active-low reset.
REQ-005 Port: pc_out  in  16  current PC value from the program counter.
REQ-006 Port: pc_in  out  16  PC load value.
REQ-007 Port: pc_ld  out  1  PC load strobe.
REQ-008 Port: pc_inc  out  1  PC increment strobe; never asserted with pc_ld.
REQ-009 Port: mem_req  out  1  instruction read request.
REQ-010 Port: mem_addr  out  16  read address; equals pc_out whenever mem_req=1.
REQ-011 Port: mem_ack  in  1  read complete; mem_rdata valid this cycle.
REQ-012 Port: mem_rdata  in  16  instruction word.
REQ-013 Port: ir  out  16  registered instruction.
REQ-014 Port: ir_valid  out  1  ir holds an unconsumed instruction.
REQ-015 Port: ir_ready  in  1  decoder accepts ir this cycle.
REQ-016 Port: br_valid  in  1  redirect request, single-cycle pulse.
REQ-017 Port: br_target  in  16  redirect address, valid with br_valid.
REQ-018 Port: halt  in  1  level; stop fetching after the current issue.
REQ-019 Port: fault  out  1  sticky fetch-timeout indication.

Function
REQ-020 States SHALL be RSTV, FETCH, ISSUE, HALT, FAULT; all outputs are decoded from state plus registered data, with no input-to-output combinational path except pc_ld/pc_inc/pc_in (REQ-024..REQ-027).
REQ-021 RSTV: pc_ld=1, pc_in=RESET_VEC; next state FETCH unconditionally.
REQ-022 FETCH: mem_req=1, mem_addr=pc_out; wait_cnt increments each cycle without mem_ack and clears on entry to FETCH.
REQ-023 FETCH with mem_ack and no branch pending: ir <= mem_rdata; next state ISSUE (one-cycle minimum fetch latency).
REQ-024 ISSUE: ir_valid=1; on ir_ready with br_valid=0: pc_inc=1 for exactly one cycle; next state HALT if halt=1, else FETCH.
REQ-025 ISSUE with br_valid=1: pc_ld=1, pc_in=br_target, ir discarded, pc_inc=0, next state FETCH; a branch takes priority over ir_ready in the same cycle.
REQ-026 FETCH with br_valid=1: br_pend <= 1, br_tgt <= br_target; the outstanding request is held until mem_ack (no request abandonment). A later br_valid overwrites br_tgt.
REQ-027 FETCH with mem_ack and (br_pend=1 or br_valid=1): rdata discarded, pc_ld=1, pc_in = br_target if br_valid else br_tgt; br_pend cleared; next state FETCH (re-fetch at the target).
REQ-028 HALT: mem_req=0, ir_valid=0; next state FETCH when halt=0; br_valid ignored.
REQ-029 Timeout: in FETCH, if mem_ack=0 and wait_cnt = MAX_WAIT-1, next state FAULT.
REQ-030 FAULT: fault=1, mem_req=0, pc_ld=0, pc_inc=0, ir_valid=0; exits only through reset.
REQ-031 br_valid in RSTV, HALT, or FAULT SHALL be ignored.

Reset
REQ-032 When reset=0 at a rising edge: state<=RSTV, ir<=0, wait_cnt<=0, br_pend<=0, br_tgt<=0.
REQ-033 Reset mid-fetch drops the outstanding request: mem_req=0 in the cycle after the reset edge; a late mem_ack in RSTV is ignored.
REQ-034 Output values in RSTV: pc_ld=1, pc_in=RESET_VEC, mem_req=0, pc_inc=0, ir_valid=0, fault=0.

Structure
REQ-035 Package fetch_ctrl_pkg SHALL hold the state enum and the XLEN=16 constant.
REQ-036 Timeout counter SHALL be the sub-module fetch_wdog (inputs clr, en; output expired).

Verification
REQ-037 Reset release with RESET_VEC=16'h0100, mem_ack one cycle after req -> pc_ld 1 cycle, mem_addr=16'h0100, ir=mem_rdata, ir_valid, pc_inc once per accepted instruction.
REQ-038 ir_ready held low 5 cycles in ISSUE -> ir_valid stable and ir unchanged, no pc_inc, mem_req=0.
REQ-039 br_valid target 16'h0040 during FETCH wait, mem_ack 3 cycles later -> data discarded, pc_ld with 16'h0040, next mem_addr=16'h0040.
REQ-040 br_valid and ir_ready same cycle in ISSUE -> pc_ld=1, pc_inc=0, ir not consumed.
REQ-041 mem_ack never asserted, MAX_WAIT=16 -> fault=1 after 16 FETCH cycles, sticky; reset clears it and restarts at RESET_VEC.
REQ-042 halt=1 at accept -> HALT, mem_req=0 until halt=0, then fetch at the incremented PC.
